// File: rtl/mem_arbiter.sv
// Off-chip memory port arbiter: icache/dcache miss sequencing (writeback, fill, response).
// Optional build macro MEM_ARB_DCACHE_PRIORITY_EN: dcache strictly wins simultaneous requests.
module mem_arbiter #(
  parameter int unsigned addr_width       = 16,
  parameter int unsigned line_offset_bits = 5,
  parameter int unsigned mem_latency      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  icache_req,
  input  logic [addr_width-1:0] icache_addr,
  input  logic                  dcache_req,
  input  logic [addr_width-1:0] dcache_addr,
  input  logic                  dcache_dirty,
  input  logic [addr_width-1:0] dcache_victim_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic                  fill_valid,
  output logic                  icache_done,
  output logic                  dcache_done,
  output logic                  busy
);

  localparam int unsigned           cnt_w       = $clog2(mem_latency);
  localparam logic [cnt_w-1:0]      cnt_load    = cnt_w'(mem_latency - 1);
  localparam logic [addr_width-1:0] offset_mask = addr_width'((1 << line_offset_bits) - 1);

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_wb   = 2'd1;
  localparam logic [1:0] st_fill = 2'd2;
  localparam logic [1:0] st_resp = 2'd3;

  logic [1:0]            state, state_n;
  logic [cnt_w-1:0]      cnt, cnt_n;
  logic                  owner, owner_n;
  logic                  last_grant, last_grant_n;
  logic [addr_width-1:0] fill_addr, fill_addr_n;
  logic [addr_width-1:0] mem_addr_n;
  logic                  mem_we_n;
  logic                  pick_d;

  // Winner when the arbiter is idle: 1 selects dcache
  always_comb begin
    if (icache_req && dcache_req) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
      pick_d = 1'b1;
`else
      pick_d = ~last_grant;
`endif
    end else begin
      pick_d = dcache_req;
    end
  end

  // Next-state and next-command computation
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    owner_n      = owner;
    last_grant_n = last_grant;
    fill_addr_n  = fill_addr;
    mem_addr_n   = mem_addr;
    mem_we_n     = mem_we;
    case (state)
      st_idle: begin
        if (icache_req || dcache_req) begin
          owner_n      = pick_d;
          last_grant_n = pick_d;
          cnt_n        = cnt_load;
          fill_addr_n  = (pick_d ? dcache_addr : icache_addr) & ~offset_mask;
          if (pick_d && dcache_dirty) begin
            state_n    = st_wb;
            mem_we_n   = 1'b1;
            mem_addr_n = dcache_victim_addr & ~offset_mask;
          end else begin
            state_n    = st_fill;
            mem_we_n   = 1'b0;
            mem_addr_n = fill_addr_n;
          end
        end
      end
      st_wb: begin
        if (cnt == '0) begin
          state_n    = st_fill;
          cnt_n      = cnt_load;
          mem_we_n   = 1'b0;
          mem_addr_n = fill_addr;
        end else begin
          cnt_n = cnt - cnt_w'(1);
        end
      end
      st_fill: begin
        if (cnt == '0) begin
          state_n = st_resp;
        end else begin
          cnt_n = cnt - cnt_w'(1);
        end
      end
      st_resp: state_n = st_idle;
      default: state_n = st_idle;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= st_idle;
      cnt         <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b0;
      fill_addr   <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_req     <= 1'b0;
      fill_valid  <= 1'b0;
      icache_done <= 1'b0;
      dcache_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      owner       <= owner_n;
      last_grant  <= last_grant_n;
      fill_addr   <= fill_addr_n;
      mem_addr    <= mem_addr_n;
      mem_we      <= mem_we_n;
      mem_req     <= (state_n == st_wb) || (state_n == st_fill);
      fill_valid  <= (state_n == st_fill) && (cnt_n == '0);
      icache_done <= (state_n == st_resp) && !owner_n;
      dcache_done <= (state_n == st_resp) && owner_n;
      busy        <= (state_n != st_idle);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected transactions, a monitor
// reconstructs each observed memory transaction and compares it when a done pulse appears.
module tb_mem_arbiter;

  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_req, dcache_req, dcache_dirty;
  logic [15:0] icache_addr, dcache_addr, dcache_victim_addr;
  logic        mem_req, mem_we, fill_valid, icache_done, dcache_done, busy;
  logic [15:0] mem_addr;

  typedef struct {
    logic        own;
    logic        dirty;
    logic [15:0] wb_addr;
    logic [15:0] fill_addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(.addr_width(16), .line_offset_bits(5), .mem_latency(LAT)) dut (
    .clk(clk), .reset(reset),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_addr(dcache_addr),
    .dcache_dirty(dcache_dirty), .dcache_victim_addr(dcache_victim_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .fill_valid(fill_valid), .icache_done(icache_done), .dcache_done(dcache_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic own, input logic dirty, input logic [15:0] wb, input logic [15:0] miss);
    exp_t e;
    e.own = own; e.dirty = dirty;
    e.wb_addr = wb & 16'hFFE0;
    e.fill_addr = miss & 16'hFFE0;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_fill_valid"}, 32'(fill_valid), 0);
    check({tag, "_icache_done"}, 32'(icache_done), 0);
    check({tag, "_dcache_done"}, 32'(dcache_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Requester models: hold req until done, drop on the following edge
  task automatic ic_txn(input logic [15:0] a);
    bit seen = 1'b0;
    icache_addr = a;
    icache_req  = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (icache_done) seen = 1'b1;
    end
    check("icache_done_timeout", 32'(seen), 1);
    @(posedge clk); #1;
    icache_req = 1'b0;
  endtask

  task automatic dc_txn(input logic [15:0] a, input logic dirty, input logic [15:0] victim);
    bit seen = 1'b0;
    dcache_addr = a;
    dcache_dirty = dirty;
    dcache_victim_addr = victim;
    dcache_req = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (dcache_done) seen = 1'b1;
    end
    check("dcache_done_timeout", 32'(seen), 1);
    @(posedge clk); #1;
    dcache_req = 1'b0;
  endtask

  // Monitor: rebuild each transaction from the memory port, score it on done
  int          wb_n, fill_n, fv_cnt, fv_pos;
  logic [15:0] wb_a, fill_a;
  bit          prev_fv, chk_idle;

  always @(negedge clk) begin
    if (!reset) begin
      wb_n = 0; fill_n = 0; fv_cnt = 0; fv_pos = 0; prev_fv = 0; chk_idle = 0;
    end else begin
      check("both_done", 32'(icache_done & dcache_done), 0);
      if (mem_req) begin
        check("addr_align", 32'(mem_addr[4:0]), 0);
        check("busy_during_req", 32'(busy), 1);
        check("done_during_req", 32'(icache_done | dcache_done), 0);
        if (mem_we) begin
          check("wb_after_fill", 32'(fill_n), 0);
          if (wb_n == 0) wb_a = mem_addr;
          else check("wb_addr_stable", 32'(mem_addr), 32'(wb_a));
          wb_n++;
        end else begin
          if (fill_n == 0) fill_a = mem_addr;
          else check("fill_addr_stable", 32'(mem_addr), 32'(fill_a));
          fill_n++;
          if (fill_valid) begin fv_cnt++; fv_pos = fill_n; end
        end
      end else begin
        check("fill_valid_outside_fill", 32'(fill_valid), 0);
      end
      if (icache_done || dcache_done) begin
        check("resp_busy", 32'(busy), 1);
        check("done_follows_fill_valid", 32'(prev_fv), 1);
        check("expectation_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("owner", 32'(dcache_done), 32'(e.own));
          check("wb_cycles", 32'(wb_n), e.dirty ? 32'(LAT) : 32'd0);
          if (e.dirty) check("wb_addr", 32'(wb_a), 32'(e.wb_addr));
          check("fill_cycles", 32'(fill_n), 32'(LAT));
          check("fill_addr", 32'(fill_a), 32'(e.fill_addr));
          check("fill_valid_count", 32'(fv_cnt), 1);
          check("fill_valid_position", 32'(fv_pos), 32'(LAT));
        end
        wb_n = 0; fill_n = 0; fv_cnt = 0; fv_pos = 0;
        chk_idle = 1;
      end else if (chk_idle) begin
        check("idle_after_resp_busy", 32'(busy), 0);
        check("idle_after_resp_mem_req", 32'(mem_req), 0);
        chk_idle = 0;
      end
      prev_fv = fill_valid;
    end
  end

  initial begin
    logic [15:0] ra, rv;
    logic        rd;
    reset = 1'b0;
    icache_req = 1'b0; dcache_req = 1'b0; dcache_dirty = 1'b0;
    icache_addr = '0; dcache_addr = '0; dcache_victim_addr = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    step(1);
    reset = 1'b1;
    step(1);

    // Clean icache miss
    push(1'b0, 1'b0, 16'h0000, 16'h1234);
    ic_txn(16'h1234);
    step(2);

    // Dirty dcache miss: writeback then fill
    push(1'b1, 1'b1, 16'h8040, 16'h0065);
    dc_txn(16'h0065, 1'b1, 16'h8040);
    dcache_dirty = 1'b0;
    step(2);

    // Simultaneous requests from reset; dcache re-requests immediately
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    push(1'b1, 1'b0, 16'h0000, 16'h2345);
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    push(1'b1, 1'b0, 16'h0000, 16'h5678);
    push(1'b0, 1'b0, 16'h0000, 16'h4567);
`else
    push(1'b0, 1'b0, 16'h0000, 16'h4567);
    push(1'b1, 1'b0, 16'h0000, 16'h5678);
`endif
    fork
      ic_txn(16'h4567);
      begin
        dc_txn(16'h2345, 1'b0, 16'h0000);
        dc_txn(16'h5678, 1'b0, 16'h0000);
      end
    join
    step(2);

    // Request raised during another owner's fill waits for idle
    push(1'b0, 1'b0, 16'h0000, 16'h0ABC);
    push(1'b1, 1'b0, 16'h0000, 16'h1111);
    fork
      ic_txn(16'h0ABC);
      begin
        step(4);
        dc_txn(16'h1111, 1'b0, 16'h0000);
      end
    join
    step(2);

    // Reset in the middle of a writeback; pending icache request then gets a full fill
    dcache_addr = 16'h3000; dcache_dirty = 1'b1; dcache_victim_addr = 16'h9000;
    dcache_req = 1'b1;
    step(1);
    push(1'b0, 1'b0, 16'h0000, 16'h7777);
    fork
      ic_txn(16'h7777);
      begin
        repeat (5) @(negedge clk);
        check("mid_wb_we", 32'(mem_we), 1);
        check("mid_wb_addr", 32'(mem_addr), 32'h9000);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        dcache_req = 1'b0; dcache_dirty = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
      end
    join
    step(2);

    // Random addresses, alternating requesters
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rv = 16'($urandom);
      rd = 1'($urandom_range(0, 1));
      if (i % 2 == 0) begin
        push(1'b0, 1'b0, 16'h0000, ra);
        ic_txn(ra);
      end else begin
        push(1'b1, rd, rv, ra);
        dc_txn(ra, rd, rv);
        dcache_dirty = 1'b0;
      end
      step(1);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single off-chip memory port between instruction-cache and data-cache miss requests and sequences each transaction: an optional dirty-line writeback, then a line fill, then a one-cycle response. It sits beside the TLB/cache stages. The TLB stage raises a data-cache request on a miss; the fetch stage raises an instruction-cache request. The arbiter drives the memory command signals and tells each cache when its fill data is valid.

## Interface
- `addr_width`, 16, width of byte addresses
- `line_offset_bits`, 5, log2 of bytes per line (32-byte lines)
- `mem_latency`, 10, cycles memory needs per line read or write (≥2)
- `clk` input 1: sole clock, rising edge
- `reset` input 1: asynchronous, active-low reset
- `icache_req` input 1: icache miss pending; held high until `icache_done`
- `icache_addr` input addr_width: miss address (offset bits ignored)
- `dcache_req` input 1: dcache miss pending; held high until `dcache_done`
- `dcache_addr` input addr_width: miss address
- `dcache_dirty` input 1: victim line is dirty; sampled at grant
- `dcache_victim_addr` input addr_width: victim line address; sampled at grant
- `mem_req` output 1: memory command active
- `mem_we` output 1: 1 = line write (writeback), 0 = line read
- `mem_addr` output addr_width: line-aligned address; low `line_offset_bits` bits always 0
- `fill_valid` output 1: memory read data valid this cycle (last FILL cycle)
- `icache_done` output 1: one-cycle pulse; icache fill complete
- `dcache_done` output 1: one-cycle pulse; dcache fill complete
- `busy` output 1: state ≠ IDLE

## Operation
- States: IDLE, WB, FILL, RESP. `owner` register: 0 = icache, 1 = dcache. `last_grant` register tracks the last owner. Down-counter `cnt` is `$clog2(mem_latency)` bits wide.
- IDLE, no request pending: remain in IDLE.
- IDLE, one request pending: grant that requester.
- IDLE, both requests pending: round-robin; the requester not equal to `last_grant` wins.
- On grant, latch `owner` and the line-aligned miss address, and update `last_grant`. For dcache, also latch `dcache_dirty` and the victim address.
- Grant to dcache with dirty = 1: go to WB with `mem_we` = 1, `mem_addr` = victim, `cnt` = mem_latency−1. Every other grant goes to FILL with `mem_we` = 0, `mem_addr` = miss line, `cnt` = mem_latency−1.
- WB: `cnt` decrements each cycle. At `cnt` = 0, go to FILL, reload `cnt`, and switch `mem_we` and `mem_addr` to the read.
- FILL: `cnt` decrements. At `cnt` = 0, `fill_valid` = 1 combinationally, then go to RESP.
- RESP: the owner's done output is 1 and `mem_req` = 0. Next state is IDLE unconditionally.
- The requester drops req on the edge after done. IDLE therefore never sees a stale request.
- Request inputs are ignored outside IDLE. A request that rises mid-transaction waits.
- `mem_req` = 1 exactly in WB and FILL.
- `mem_addr` and `mem_we` are registered and stable for the whole phase. `mem_addr` is held at its last value (not zeroed) in RESP/IDLE.
- Reset (asynchronous, any state including mid-WB/FILL): state ← IDLE, `cnt` ← 0, `owner` ← 0, `last_grant` ← 0 (icache), so dcache wins the first tie. The aborted memory transaction is simply dropped and no done is issued.
- Reset values: `mem_req` 0, `mem_we` 0, `mem_addr` 0, `fill_valid` 0, `icache_done` 0, `dcache_done` 0, `busy` 0.

## Timing
- Request high before edge E0 (arbiter in IDLE): WB or FILL begins at E0.
- Clean miss: FILL occupies mem_latency cycles; `fill_valid` is in the last one; done is in the following cycle. Done is mem_latency+1 cycles after the grant edge.
- Dirty miss: done is 2·mem_latency+1 cycles after grant.
- Minimum spacing between consecutive grants: one IDLE cycle after RESP. Transaction period = latency+2 (clean) or 2·latency+2 (dirty).
- Done pulses are exactly one cycle, never both in the same cycle, and never while `mem_req` = 1.

## Configuration
- `MEM_ARB_DCACHE_PRIORITY_EN`
  - Defined: dcache strictly wins whenever both requests are pending in IDLE; `last_grant` is still updated but unused.
  - Undefined: round-robin as above.

## Test plan
- Clean icache miss, `icache_addr` = 16'h1234, latency 10, no dcache request → `mem_addr` = 16'h1220, `mem_we` = 0, `mem_req` high 10 cycles, `fill_valid` on the 10th, `icache_done` one cycle later; `busy` low the cycle after.
- Dirty dcache miss, victim 16'h8040, miss 16'h0065 → 10 cycles `mem_we` = 1 at 16'h8040, then 10 cycles `mem_we` = 0 at 16'h0060, then `dcache_done`; `icache_done` stays 0.
- Both requests held simultaneously from reset → dcache served first, then icache, then dcache again (round-robin). With `MEM_ARB_DCACHE_PRIORITY_EN` and dcache re-requesting immediately → dcache served every time; icache starves as specified.
- Request raised during FILL of another owner → ignored until IDLE, then granted; no done pulse merges or overlaps.
- `reset` asserted low at cycle 5 of a WB → all outputs 0 immediately (asynchronously); after release with `icache_req` still high, a fresh FILL starts with full latency.
- `mem_addr` low 5 bits checked 0 on every `mem_req` cycle across random addresses.
